ysyx_22050550_wbu: RTL and testbench
====================================

YSYX_22050550_WBU -- requirements
Module: ysyx_22050550_wbu

Interface
REQ-001 SHALL: clock  in  1  clock; all state updates on posedge.
REQ-002 SHALL: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL: in_valid / in_ready  in / out  1 / 1  LS->WB handshake.
REQ-004 SHALL: in_pc, in_nextpc  in  64  instruction PC; sequential/branch next PC.
REQ-005 SHALL: in_inst  in  32  instruction word.
REQ-006 SHALL: in_rs1  in  5  rs1 field, used as zimm in CSR-immediate forms.
REQ-007 SHALL: in_wdaddr, in_wen  in  5, 1  destination register; write request.
REQ-008 SHALL: in_alures, in_lsures  in  64, 64  ALU result / CSR source; load data.
REQ-009 SHALL: in_csrflag, in_ecallflag, in_mretflag, in_ebreak, in_abort  in  1 each  decode flags.
REQ-010 SHALL: in_func3  in  3  CSR op select.
REQ-011 SHALL: rf_wen, rf_waddr, rf_wdata  out  1, 5, 64  register-file write port.
REQ-012 SHALL: redirect_valid, redirect_pc  out  1, 64  trap/mret redirect to fetch.
REQ-013 SHALL: commit_valid, commit_pc, commit_nextpc  out  1, 64, 64  retire report.
REQ-014 SHALL: halt  out  1  sticky, set by ebreak retire.
REQ-015 SHALL: instret  out  64  retired-instruction counter.

Function
REQ-016 SHALL: capture all in_* into a one-entry stage register when in_valid && in_ready; entry valid flag <= (in_valid && in_ready && !redirect_valid) every cycle.
REQ-017 SHALL: in_ready = !halt; the entry drains every cycle, so capture and retire of the previous entry coincide without stall.
REQ-018 SHALL: retire the entry in the cycle after capture; all outputs except instret, halt and the CSR registers are combinational from the entry.
REQ-019 SHALL: entry with abort=1 retires silently: rf_wen=0, no CSR update, no redirect, commit_valid=0, instret unchanged.
REQ-020 SHALL: rf_wen = entry valid && wen && wdaddr!=0 && !abort.
REQ-021 SHALL: rf_wdata = lsures if inst[6:0]==7'b0000011; old CSR value if csrflag; else alures.
REQ-022 SHALL: implement mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342 (64-bit each); CSR address = inst[31:20]; other addresses read 0, writes ignored.
REQ-023 SHALL: CSR source = alures for func3 001/010/011, zero-extended rs1 for 101/110/111; RW: csr<=src; RS: csr<=csr|src; RC: csr<=csr&~src; RS/RC with src==0 do not write.
REQ-024 SHALL: on ecall retire: mepc<=pc, mcause<=64'd11, mstatus.MPIE<=MIE, MIE<=0, MPP<=2'b11; redirect_valid=1, redirect_pc=mtvec.
REQ-025 SHALL: on mret retire: mstatus.MIE<=MPIE, MPIE<=1, MPP<=0; redirect_valid=1, redirect_pc=mepc.
REQ-026 SHALL: when redirect_valid=1, the concurrently offered in_* is discarded (wrong path); in_ready still reads 1.
REQ-027 SHALL: commit_valid = entry valid && !abort; commit_nextpc = redirect_pc if redirect, else nextpc.
REQ-028 SHALL: instret += 1 on each cycle commit_valid=1; wraps 2^64-1 -> 0.
REQ-029 SHALL: ebreak retire sets halt=1 next cycle; afterwards in_ready=0, no further captures, until reset.
REQ-030 SHALL: CSR write by a CSR instruction and trap update never coincide (single entry); ecall takes priority if both flagged.

Reset
REQ-031 SHALL: on reset: entry valid=0, halt=0, instret=0, mstatus/mtvec/mepc/mcause=0; rf_wen, redirect_valid, commit_valid=0 the cycle after reset asserts.
REQ-032 SHALL: reset mid-operation discards the held entry without register-file or CSR write.

Verification
REQ-033 SHALL: load to x5, lsures=0xDEAD, alures=0x8000_0000 -> next cycle rf_wen=1, waddr=5, wdata=0xDEAD, instret 0->1.
REQ-034 SHALL: csrrw x1,mtvec with alures=0x8000_0100, then ecall at pc 0x8000_0040 -> x1=0, redirect_pc=0x8000_0100, mepc=0x8000_0040, mcause=11.
REQ-035 SHALL: mret following REQ-034 -> redirect_pc=0x8000_0040, MIE restored; instruction offered in the redirect cycle not retired.
REQ-036 SHALL: write to x0 with wen=1 -> rf_wen=0, commit_valid=1.
REQ-037 SHALL: ebreak retire -> halt=1, in_ready=0; later in_valid ignored; reset clears halt and instret.

Source files
------------

// File: rtl/ysyx_22050550_wbu_if.sv
// LS->WB stage handshake bundle: the memory stage drives one instruction's
// retire information per beat, and the write-back stage answers with ready.
interface ysyx_22050550_wbu_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_nextpc;
  logic [31:0]       in_inst;
  logic [4:0]        in_rs1;
  logic [4:0]        in_wdaddr;
  logic              in_wen;
  logic [DATA_W-1:0] in_alures;
  logic [DATA_W-1:0] in_lsures;
  logic              in_csrflag;
  logic              in_ecallflag;
  logic              in_mretflag;
  logic              in_ebreak;
  logic              in_abort;
  logic [2:0]        in_func3;

  modport master (
    output in_valid, in_pc, in_nextpc, in_inst, in_rs1, in_wdaddr, in_wen,
           in_alures, in_lsures, in_csrflag, in_ecallflag, in_mretflag,
           in_ebreak, in_abort, in_func3,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_nextpc, in_inst, in_rs1, in_wdaddr, in_wen,
           in_alures, in_lsures, in_csrflag, in_ecallflag, in_mretflag,
           in_ebreak, in_abort, in_func3,
    output in_ready
  );
endinterface

// File: rtl/ysyx_22050550_wbu.sv
// Write-back unit: one-entry retire stage with register-file write, machine
// CSRs (mstatus/mtvec/mepc/mcause), ecall/mret redirect, halt and instret.
module ysyx_22050550_wbu #(
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  ysyx_22050550_wbu_if.slave ls,
  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              commit_valid,
  output logic [DATA_W-1:0] commit_pc,
  output logic [DATA_W-1:0] commit_nextpc,
  output logic              halt,
  output logic [DATA_W-1:0] instret
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [6:0]  OP_LOAD     = 7'b0000011;
  localparam int          MIE_BIT     = 3;
  localparam int          MPIE_BIT    = 7;

  // Does a CSR op write at all? Set/clear with a zero source leave the CSR alone.
  function automatic logic csr_we(input logic [2:0] f3, input logic [DATA_W-1:0] src);
    case (f3)
      3'b001, 3'b101:                 csr_we = 1'b1;
      3'b010, 3'b011, 3'b110, 3'b111: csr_we = (src != '0);
      default:                        csr_we = 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] csr_apply(input logic [2:0] f3,
                                                  input logic [DATA_W-1:0] old,
                                                  input logic [DATA_W-1:0] src);
    case (f3[1:0])
      2'b01:   csr_apply = src;
      2'b10:   csr_apply = old | src;
      2'b11:   csr_apply = old & ~src;
      default: csr_apply = old;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] mstatus_trap(input logic [DATA_W-1:0] ms);
    mstatus_trap = ms;
    mstatus_trap[MPIE_BIT] = ms[MIE_BIT];
    mstatus_trap[MIE_BIT] = 1'b0;
    mstatus_trap[12:11] = 2'b11;
  endfunction

  function automatic logic [DATA_W-1:0] mstatus_ret(input logic [DATA_W-1:0] ms);
    mstatus_ret = ms;
    mstatus_ret[MIE_BIT] = ms[MPIE_BIT];
    mstatus_ret[MPIE_BIT] = 1'b1;
    mstatus_ret[12:11] = 2'b00;
  endfunction

  logic              vld_p1;
  logic [DATA_W-1:0] pc_p1;
  logic [DATA_W-1:0] nextpc_p1;
  logic [31:0]       inst_p1;
  logic [4:0]        rs1_p1;
  logic [4:0]        wdaddr_p1;
  logic              wen_p1;
  logic [DATA_W-1:0] alures_p1;
  logic [DATA_W-1:0] lsures_p1;
  logic              csrflag_p1;
  logic              ecall_p1;
  logic              mret_p1;
  logic              ebreak_p1;
  logic              abort_p1;
  logic [2:0]        func3_p1;

  logic [DATA_W-1:0] mstatus;
  logic [DATA_W-1:0] mtvec;
  logic [DATA_W-1:0] mepc;
  logic [DATA_W-1:0] mcause;

  logic              capture;
  logic              retire;
  logic              trap_ecall;
  logic              trap_mret;
  logic              csr_wr;
  logic [11:0]       csr_addr;
  logic [DATA_W-1:0] csr_old;
  logic [DATA_W-1:0] csr_src;
  logic [DATA_W-1:0] csr_new;
  logic              unused_inst_bits;

  assign ls.in_ready = !halt;
  assign capture     = ls.in_valid && ls.in_ready;

  // Stage p0 -> p1: capture the offered instruction into the single entry
  always_ff @(posedge clock) begin
    if (capture) begin
      pc_p1      <= ls.in_pc;
      nextpc_p1  <= ls.in_nextpc;
      inst_p1    <= ls.in_inst;
      rs1_p1     <= ls.in_rs1;
      wdaddr_p1  <= ls.in_wdaddr;
      wen_p1     <= ls.in_wen;
      alures_p1  <= ls.in_alures;
      lsures_p1  <= ls.in_lsures;
      csrflag_p1 <= ls.in_csrflag;
      ecall_p1   <= ls.in_ecallflag;
      mret_p1    <= ls.in_mretflag;
      ebreak_p1  <= ls.in_ebreak;
      abort_p1   <= ls.in_abort;
      func3_p1   <= ls.in_func3;
    end
  end

  // An instruction offered while a redirect retires is on the wrong path.
  always_ff @(posedge clock) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= capture && !redirect_valid;
  end

  // Stage p1: retire the entry combinationally
  assign retire     = vld_p1 && !abort_p1 && !reset;
  assign trap_ecall = retire && ecall_p1;
  assign trap_mret  = retire && mret_p1 && !ecall_p1;
  assign csr_addr   = inst_p1[31:20];
  assign csr_src    = func3_p1[2] ? {{(DATA_W-5){1'b0}}, rs1_p1} : alures_p1;
  assign csr_new    = csr_apply(func3_p1, csr_old, csr_src);
  assign csr_wr     = retire && csrflag_p1 && !ecall_p1 && !mret_p1 &&
                      csr_we(func3_p1, csr_src);

  always_comb begin
    csr_old = '0;
    case (csr_addr)
      CSR_MSTATUS: csr_old = mstatus;
      CSR_MTVEC:   csr_old = mtvec;
      CSR_MEPC:    csr_old = mepc;
      CSR_MCAUSE:  csr_old = mcause;
      default:     csr_old = '0;
    endcase
  end

  assign redirect_valid = trap_ecall || trap_mret;
  assign redirect_pc    = trap_ecall ? mtvec : mepc;

  assign rf_wen   = retire && wen_p1 && (wdaddr_p1 != 5'd0);
  assign rf_waddr = wdaddr_p1;
  always_comb begin
    rf_wdata = alures_p1;
    if (inst_p1[6:0] == OP_LOAD) rf_wdata = lsures_p1;
    else if (csrflag_p1)         rf_wdata = csr_old;
  end

  assign commit_valid  = retire;
  assign commit_pc     = pc_p1;
  assign commit_nextpc = redirect_valid ? redirect_pc : nextpc_p1;

  assign unused_inst_bits = ^inst_p1[19:7];

  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus <= '0;
      mtvec   <= '0;
      mepc    <= '0;
      mcause  <= '0;
    end else if (trap_ecall) begin
      mepc    <= pc_p1;
      mcause  <= DATA_W'(11);
      mstatus <= mstatus_trap(mstatus);
    end else if (trap_mret) begin
      mstatus <= mstatus_ret(mstatus);
    end else if (csr_wr) begin
      case (csr_addr)
        CSR_MSTATUS: mstatus <= csr_new;
        CSR_MTVEC:   mtvec   <= csr_new;
        CSR_MEPC:    mepc    <= csr_new;
        CSR_MCAUSE:  mcause  <= csr_new;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      halt    <= 1'b0;
      instret <= '0;
    end else begin
      if (retire && ebreak_p1) halt <= 1'b1;
      if (commit_valid)        instret <= instret + DATA_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_22050550_wbu.sv
// Scoreboard bench for the write-back unit: an independent retire/CSR model
// queues expectations at issue time; they are popped when the entry retires.
module tb_ysyx_22050550_wbu;

  typedef struct packed {
    logic [63:0] pc, npc, alu, lsu;
    logic [31:0] inst;
    logic [4:0]  rs1, rd;
    logic        wen, csr, ecall, mret, ebreak, abort;
    logic [2:0]  f3;
  } instr_t;

  typedef struct packed {
    logic        cv, rfw, rv;
    logic [4:0]  wa;
    logic [63:0] wd, rpc, cpc, cnpc, iret;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rf_wen, redirect_valid, commit_valid, halt;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata, redirect_pc, commit_pc, commit_nextpc, instret;

  int n_chk = 0;
  int n_pass = 0;
  exp_t sbq[$];

  logic [63:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_iret;
  logic        m_halt, m_pend;

  ysyx_22050550_wbu_if ls();

  ysyx_22050550_wbu dut (
    .clock(clock), .reset(reset), .ls(ls),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_nextpc(commit_nextpc),
    .halt(halt), .instret(instret)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic instr_t base(input logic [63:0] pc);
    instr_t t = '0;
    t.pc = pc;
    t.npc = pc + 64'd4;
    return t;
  endfunction

  function automatic instr_t alu_op(input logic [4:0] rd, input logic [63:0] v, input logic [63:0] pc);
    instr_t t = base(pc);
    t.rd = rd; t.wen = 1'b1; t.alu = v;
    t.inst = {20'h0, rd, 7'b0010011};
    return t;
  endfunction

  function automatic instr_t load_op(input logic [4:0] rd, input logic [63:0] lsu,
                                     input logic [63:0] alu, input logic [63:0] pc);
    instr_t t = base(pc);
    t.rd = rd; t.wen = 1'b1; t.lsu = lsu; t.alu = alu;
    t.inst = {20'h0, rd, 7'b0000011};
    return t;
  endfunction

  function automatic instr_t csr_op(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [63:0] alu, input logic [63:0] pc);
    instr_t t = base(pc);
    t.f3 = f3; t.rd = rd; t.rs1 = rs1; t.alu = alu; t.wen = 1'b1; t.csr = 1'b1;
    t.inst = {addr, rs1, f3, rd, 7'b1110011};
    return t;
  endfunction

  function automatic instr_t sys_op(input int kind, input logic [63:0] pc);
    instr_t t = base(pc);
    t.ecall = (kind == 0); t.mret = (kind == 1); t.ebreak = (kind == 2);
    t.inst = (kind == 0) ? 32'h00000073 : (kind == 1) ? 32'h30200073 : 32'h00100073;
    return t;
  endfunction

  function automatic logic [63:0] m_rd(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 64'd0;
    endcase
  endfunction

  task automatic m_wr(input logic [11:0] a, input logic [63:0] v);
    case (a)
      12'h300: m_mstatus = v;
      12'h305: m_mtvec = v;
      12'h341: m_mepc = v;
      12'h342: m_mcause = v;
      default: ;
    endcase
  endtask

  task automatic m_reset();
    m_mstatus = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_iret = 0;
    m_halt = 0; m_pend = 0;
    sbq.delete();
  endtask

  task automatic model(input instr_t t, output exp_t e);
    logic [63:0] old, src, ms;
    e = '0;
    e.iret = m_iret;
    if (m_halt) return;
    if (m_pend) begin m_pend = 0; return; end
    if (t.abort) return;
    old = m_rd(t.inst[31:20]);
    e.cv = 1; e.cpc = t.pc; e.cnpc = t.npc;
    e.rfw = t.wen && (t.rd != 0); e.wa = t.rd;
    e.wd = (t.inst[6:0] == 7'h03) ? t.lsu : (t.csr ? old : t.alu);
    ms = m_mstatus;
    if (t.ecall) begin
      e.rv = 1; e.rpc = m_mtvec;
      m_mepc = t.pc; m_mcause = 64'd11;
      ms[7] = m_mstatus[3]; ms[3] = 1'b0; ms[12:11] = 2'b11;
      m_mstatus = ms; m_pend = 1;
    end else if (t.mret) begin
      e.rv = 1; e.rpc = m_mepc;
      ms[3] = m_mstatus[7]; ms[7] = 1'b1; ms[12:11] = 2'b00;
      m_mstatus = ms; m_pend = 1;
    end else if (t.csr) begin
      src = t.f3[2] ? {59'd0, t.rs1} : t.alu;
      if (t.f3[1:0] == 2'b01) m_wr(t.inst[31:20], src);
      else if (t.f3[1:0] == 2'b10 && src != 0) m_wr(t.inst[31:20], old | src);
      else if (t.f3[1:0] == 2'b11 && src != 0) m_wr(t.inst[31:20], old & ~src);
    end
    if (e.rv) e.cnpc = e.rpc;
    if (t.ebreak) m_halt = 1;
    m_iret = m_iret + 64'd1;
  endtask

  task automatic drive(input instr_t t);
    ls.in_valid = 1'b1;
    ls.in_pc = t.pc; ls.in_nextpc = t.npc; ls.in_inst = t.inst; ls.in_rs1 = t.rs1;
    ls.in_wdaddr = t.rd; ls.in_wen = t.wen; ls.in_alures = t.alu; ls.in_lsures = t.lsu;
    ls.in_csrflag = t.csr; ls.in_ecallflag = t.ecall; ls.in_mretflag = t.mret;
    ls.in_ebreak = t.ebreak; ls.in_abort = t.abort; ls.in_func3 = t.f3;
  endtask

  task automatic issue(input string tag, input instr_t t);
    exp_t e;
    drive(t);
    model(t, e);
    sbq.push_back(e);
    @(posedge clock); #1;
    ls.in_valid = 1'b0;
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sbq.pop_front();
    check({tag, "_commit"}, 64'(commit_valid), 64'(e.cv));
    check({tag, "_rfwen"}, 64'(rf_wen), 64'(e.rfw));
    check({tag, "_redir"}, 64'(redirect_valid), 64'(e.rv));
    check({tag, "_instret"}, instret, e.iret);
    if (e.rfw) begin
      check({tag, "_waddr"}, 64'(rf_waddr), 64'(e.wa));
      check({tag, "_wdata"}, rf_wdata, e.wd);
    end
    if (e.rv) check({tag, "_rpc"}, redirect_pc, e.rpc);
    if (e.cv) begin
      check({tag, "_cpc"}, commit_pc, e.cpc);
      check({tag, "_cnpc"}, commit_nextpc, e.cnpc);
    end
  endtask

  task automatic do_reset(input string tag);
    ls.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    m_reset();
    check({tag, "_rfwen"}, 64'(rf_wen), 64'd0);
    check({tag, "_redir"}, 64'(redirect_valid), 64'd0);
    check({tag, "_commit"}, 64'(commit_valid), 64'd0);
    check({tag, "_halt"}, 64'(halt), 64'd0);
    check({tag, "_instret"}, instret, 64'd0);
    check({tag, "_ready"}, 64'(ls.in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    instr_t t;
    ls.in_valid = 0;
    drive('0);
    ls.in_valid = 0;
    m_reset();
    @(posedge clock); #1;
    do_reset("rst0");

    issue("load_x5", load_op(5'd5, 64'hDEAD, 64'h8000_0000, 64'h8000_0000));
    issue("x0_write", alu_op(5'd0, 64'h55, 64'h8000_0004));
    issue("csrrsi_mie", csr_op(3'b110, 12'h300, 5'd0, 5'd8, 64'd0, 64'h8000_0008));
    issue("csrrw_mtvec", csr_op(3'b001, 12'h305, 5'd1, 5'd0, 64'h8000_0100, 64'h8000_000C));
    issue("ecall", sys_op(0, 64'h8000_0040));
    issue("wrong_path1", alu_op(5'd7, 64'h77, 64'h8000_0044));
    issue("rd_mepc", csr_op(3'b010, 12'h341, 5'd2, 5'd0, 64'd0, 64'h8000_0100));
    issue("rd_mcause", csr_op(3'b010, 12'h342, 5'd3, 5'd0, 64'd0, 64'h8000_0104));
    issue("rd_mstat_trap", csr_op(3'b010, 12'h300, 5'd4, 5'd0, 64'd0, 64'h8000_0108));
    issue("mret", sys_op(1, 64'h8000_010C));
    issue("wrong_path2", alu_op(5'd8, 64'h88, 64'h8000_0110));
    issue("rd_mstat_ret", csr_op(3'b010, 12'h300, 5'd4, 5'd0, 64'd0, 64'h8000_0044));
    t = alu_op(5'd9, 64'h99, 64'h8000_0048);
    t.abort = 1'b1;
    issue("abort", t);
    issue("csrrs_mtvec", csr_op(3'b010, 12'h305, 5'd10, 5'd0, 64'hF, 64'h8000_004C));
    issue("csrrc_mtvec", csr_op(3'b011, 12'h305, 5'd11, 5'd0, 64'h100, 64'h8000_0050));
    issue("csrrci_zero", csr_op(3'b111, 12'h305, 5'd12, 5'd0, 64'd0, 64'h8000_0054));
    issue("csr_unmapped", csr_op(3'b001, 12'h7C0, 5'd13, 5'd0, 64'h1234, 64'h8000_0058));
    issue("rd_mtvec", csr_op(3'b010, 12'h305, 5'd14, 5'd0, 64'd0, 64'h8000_005C));
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0)
        issue("rnd_load", load_op(5'($urandom_range(0, 31)), {$urandom, $urandom},
                                  {$urandom, $urandom}, 64'h8000_1000 + 64'(i * 4)));
      else
        issue("rnd_alu", alu_op(5'($urandom_range(0, 31)), {$urandom, $urandom},
                                64'h8000_1000 + 64'(i * 4)));
    end

    // Reset with an entry held must not write the register file or CSRs.
    drive(csr_op(3'b001, 12'h305, 5'd9, 5'd0, 64'h1234, 64'h8000_2000));
    @(posedge clock); #1;
    ls.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_rfwen", 64'(rf_wen), 64'd0);
    check("midrst_commit", 64'(commit_valid), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    m_reset();
    check("midrst_instret", instret, 64'd0);
    issue("midrst_mtvec", csr_op(3'b010, 12'h305, 5'd2, 5'd0, 64'd0, 64'h8000_2004));

    issue("ebreak", sys_op(2, 64'h8000_3000));
    @(posedge clock); #1;
    check("halt_set", 64'(halt), 64'd1);
    check("halt_ready", 64'(ls.in_ready), 64'd0);
    issue("after_halt", alu_op(5'd6, 64'h66, 64'h8000_3004));
    check("halt_sticky", 64'(halt), 64'd1);
    do_reset("rst_end");
    issue("post_rst", alu_op(5'd6, 64'h66, 64'h8000_0000));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
